// File: rtl/sync_updown_counter_if.sv
// Control and status bundle for sync_updown_counter_n.
// The master drives the strobes and direction; the counter (slave) returns count and flags.
interface sync_updown_counter_if #(
   parameter int unsigned WIDTH = 4
);
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             en;
   logic             up_dn;
   logic [WIDTH-1:0] q;
   logic             tc_o;
   logic             wrap_o;
   logic             ovf_o;

   modport master (
      output clr, load, load_val, en, up_dn,
      input  q, tc_o, wrap_o, ovf_o
   );

   modport slave (
      input  clr, load, load_val, en, up_dn,
      output q, tc_o, wrap_o, ovf_o
   );
endinterface

// File: rtl/sync_updown_counter_n.sv
// Parametrised synchronous up/down counter with programmable modulus, load, clear,
// wrap/saturate mode, and terminal-count / wrap / sticky-overflow flags.
module sync_updown_counter_n #(
   parameter int unsigned      WIDTH     = 4,
   parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter bit               SATURATE  = 1'b0
) (
   input logic                 clk,
   input logic                 rst,
   sync_updown_counter_if.slave bus
);
   logic             limit_hit;
   logic [WIDTH-1:0] load_clamped;

   // Limit depends on direction so that tc_o chains cleanly into the next stage's en.
   assign limit_hit    = bus.up_dn ? (bus.q == MAX_VAL) : (bus.q == '0);
   assign bus.tc_o     = bus.en & limit_hit;
   assign load_clamped = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.q      <= RESET_VAL;
         bus.wrap_o <= 1'b0;
         bus.ovf_o  <= 1'b0;
      end else if (bus.clr) begin
         bus.q      <= '0;
         bus.wrap_o <= 1'b0;
         bus.ovf_o  <= 1'b0;
      end else if (bus.load) begin
         bus.q      <= load_clamped;
         bus.wrap_o <= 1'b0;
      end else if (bus.en) begin
         bus.wrap_o <= 1'b0;
         if (limit_hit) begin
            bus.ovf_o <= 1'b1;
            if (!SATURATE) begin
               bus.q      <= bus.up_dn ? '0 : MAX_VAL;
               bus.wrap_o <= 1'b1;
            end
         end else begin
            bus.q <= bus.up_dn ? bus.q + WIDTH'(1) : bus.q - WIDTH'(1);
         end
      end else begin
         bus.wrap_o <= 1'b0;
      end
   end
endmodule

// File: tb/tb_sync_updown_counter_n.sv
// Directed self-checking bench for sync_updown_counter_n across several parameter sets.
module tb_sync_updown_counter_n;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   sync_updown_counter_if #(.WIDTH(4)) a_if ();   // default modulus, wrap
   sync_updown_counter_if #(.WIDTH(4)) b_if ();   // MAX_VAL=9, wrap
   sync_updown_counter_if #(.WIDTH(4)) c_if ();   // MAX_VAL=9, saturate
   sync_updown_counter_if #(.WIDTH(4)) d_if ();   // MAX_VAL=9, RESET_VAL=4
   sync_updown_counter_if #(.WIDTH(4)) c0_if ();  // cascade low
   sync_updown_counter_if #(.WIDTH(4)) c1_if ();  // cascade high
   sync_updown_counter_if #(.WIDTH(2)) z_if ();   // MAX_VAL=0

   sync_updown_counter_n #(.WIDTH(4)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
   sync_updown_counter_n #(.WIDTH(4), .MAX_VAL(4'd9)) dut_b (.clk(clk), .rst(rst), .bus(b_if));
   sync_updown_counter_n #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(c_if));
   sync_updown_counter_n #(.WIDTH(4), .MAX_VAL(4'd9), .RESET_VAL(4'd4)) dut_d (.clk(clk), .rst(rst), .bus(d_if));
   sync_updown_counter_n #(.WIDTH(4)) dut_c0 (.clk(clk), .rst(rst), .bus(c0_if));
   sync_updown_counter_n #(.WIDTH(4)) dut_c1 (.clk(clk), .rst(rst), .bus(c1_if));
   sync_updown_counter_n #(.WIDTH(2), .MAX_VAL(2'd0)) dut_z (.clk(clk), .rst(rst), .bus(z_if));

   assign c1_if.en = c0_if.tc_o;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   int wraps_hi;
   int exp_q;

   initial begin
      {a_if.clr, a_if.load, a_if.load_val, a_if.en, a_if.up_dn} = '0;
      {b_if.clr, b_if.load, b_if.load_val, b_if.en, b_if.up_dn} = '0;
      {c_if.clr, c_if.load, c_if.load_val, c_if.en, c_if.up_dn} = '0;
      {d_if.clr, d_if.load, d_if.load_val, d_if.en, d_if.up_dn} = '0;
      {c0_if.clr, c0_if.load, c0_if.load_val, c0_if.en, c0_if.up_dn} = '0;
      {c1_if.clr, c1_if.load, c1_if.load_val} = '0;
      c1_if.up_dn = 1'b1;
      {z_if.clr, z_if.load, z_if.load_val, z_if.en, z_if.up_dn} = '0;

      rst = 1'b1;
      tick;
      rst = 1'b0;
      check("rst_a_q", 32'(a_if.q), 0);
      check("rst_a_wrap", 32'(a_if.wrap_o), 0);
      check("rst_a_ovf", 32'(a_if.ovf_o), 0);
      check("rst_d_q", 32'(d_if.q), 4);

      // Full-range up count with wrap
      a_if.en = 1'b1;
      a_if.up_dn = 1'b1;
      #1;
      for (int i = 0; i < 17; i++) begin
         check("t1_tc", 32'(a_if.tc_o), 32'((i % 16) == 15));
         tick;
         check("t1_q", 32'(a_if.q), (i + 1) % 16);
         check("t1_wrap", 32'(a_if.wrap_o), 32'(i == 15));
         check("t1_ovf", 32'(a_if.ovf_o), 32'(i >= 15));
      end
      a_if.en = 1'b0;

      // Load keeps ovf, idle holds, clr clears
      a_if.load = 1'b1;
      a_if.load_val = 4'd12;
      tick;
      a_if.load = 1'b0;
      check("t6_load_q", 32'(a_if.q), 12);
      check("t6_load_ovf", 32'(a_if.ovf_o), 1);
      for (int i = 0; i < 5; i++) begin
         tick;
         check("t6_idle_q", 32'(a_if.q), 12);
         check("t6_idle_wrap", 32'(a_if.wrap_o), 0);
         check("t6_idle_ovf", 32'(a_if.ovf_o), 1);
      end
      a_if.clr = 1'b1;
      tick;
      a_if.clr = 1'b0;
      check("t6_clr_q", 32'(a_if.q), 0);
      check("t6_clr_ovf", 32'(a_if.ovf_o), 0);

      // Modulus 10, down count wraps to 9
      b_if.en = 1'b1;
      b_if.up_dn = 1'b0;
      #1;
      check("t2_tc0", 32'(b_if.tc_o), 1);
      tick;
      check("t2_q9", 32'(b_if.q), 9);
      check("t2_wrap", 32'(b_if.wrap_o), 1);
      check("t2_ovf", 32'(b_if.ovf_o), 1);
      check("t2_tc9", 32'(b_if.tc_o), 0);
      tick;
      check("t2_q8", 32'(b_if.q), 8);
      check("t2_wrap_end", 32'(b_if.wrap_o), 0);
      tick;
      check("t2_q7", 32'(b_if.q), 7);
      b_if.en = 1'b0;
      b_if.load = 1'b1;
      b_if.load_val = 4'd12;
      tick;
      b_if.load = 1'b0;
      check("t2_clamp", 32'(b_if.q), 9);
      check("t2_tc_dis", 32'(b_if.tc_o), 0);

      // Saturate mode, up then reverse, then floor
      c_if.load = 1'b1;
      c_if.load_val = 4'd7;
      tick;
      c_if.load = 1'b0;
      c_if.en = 1'b1;
      c_if.up_dn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick;
         check("t3_q", 32'(c_if.q), (i == 0) ? 8 : 9);
         check("t3_wrap", 32'(c_if.wrap_o), 0);
         check("t3_ovf", 32'(c_if.ovf_o), 32'(i >= 2));
      end
      c_if.up_dn = 1'b0;
      tick;
      check("t3_dn", 32'(c_if.q), 8);
      c_if.clr = 1'b1;
      tick;
      c_if.clr = 1'b0;
      check("t3_clr_ovf", 32'(c_if.ovf_o), 0);
      tick;
      check("t3_floor_q", 32'(c_if.q), 0);
      check("t3_floor_wrap", 32'(c_if.wrap_o), 0);
      check("t3_floor_ovf", 32'(c_if.ovf_o), 1);
      c_if.en = 1'b0;

      // Priority: rst > clr > load > en
      d_if.load = 1'b1;
      d_if.load_val = 4'd9;
      tick;
      d_if.load = 1'b0;
      d_if.en = 1'b1;
      d_if.up_dn = 1'b1;
      tick;
      d_if.en = 1'b0;
      check("t4_pre_ovf", 32'(d_if.ovf_o), 1);
      d_if.load = 1'b1;
      d_if.load_val = 4'd5;
      tick;
      check("t4_q5", 32'(d_if.q), 5);
      check("t4_q5_ovf", 32'(d_if.ovf_o), 1);
      d_if.load_val = 4'd3;
      d_if.en = 1'b1;
      d_if.clr = 1'b1;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check("t4_rst_q", 32'(d_if.q), 4);
      check("t4_rst_ovf", 32'(d_if.ovf_o), 0);
      tick;
      check("t4_clr_q", 32'(d_if.q), 0);
      d_if.clr = 1'b0;
      tick;
      check("t4_load_q", 32'(d_if.q), 3);
      d_if.load = 1'b0;
      d_if.en = 1'b0;

      // The rst above also reset the cascade pair to 0.
      c0_if.en = 1'b1;
      c0_if.up_dn = 1'b1;
      wraps_hi = 0;
      for (int i = 1; i <= 256; i++) begin
         tick;
         if (c1_if.wrap_o) wraps_hi++;
         check("t5_comb", 32'({c1_if.q, c0_if.q}), i % 256);
      end
      c0_if.en = 1'b0;
      tick;
      if (c1_if.wrap_o) wraps_hi++;
      check("t5_hi_wraps", wraps_hi, 1);
      check("t5_lo_q", 32'(c0_if.q), 0);
      check("t5_hi_q", 32'(c1_if.q), 0);

      // MAX_VAL=0: every enabled edge wraps
      z_if.en = 1'b1;
      z_if.up_dn = 1'b1;
      #1;
      check("tz_tc", 32'(z_if.tc_o), 1);
      for (int i = 0; i < 3; i++) begin
         tick;
         check("tz_q", 32'(z_if.q), 0);
         check("tz_wrap", 32'(z_if.wrap_o), 1);
         check("tz_ovf", 32'(z_if.ovf_o), 1);
      end
      z_if.up_dn = 1'b0;
      #1;
      check("tz_tc_dn", 32'(z_if.tc_o), 1);
      z_if.en = 1'b0;
      tick;
      check("tz_wrap_off", 32'(z_if.wrap_o), 0);

      exp_q = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/sync_updown_counter_n.md
Name: sync_updown_counter_n

Overview:
- Parametrised synchronous successor to the team's 4-bit ripple up counter.
- Single-clock N-bit counter with:
  - up/down direction
  - programmable modulus
  - parallel load and synchronous clear
  - wrap or saturate mode
  - terminal-count and wrap-event flags
- Used as a general event/divider counter.
- Cascadable through tc_o for wider chains without ripple clocking.

Parameters:
- WIDTH, 4, counter width in bits (1..32).
- MAX_VAL, 2**WIDTH-1, highest count value; count range is 0..MAX_VAL; must be ≤ 2**WIDTH-1.
- RESET_VAL, 0, value loaded on rst; must be ≤ MAX_VAL.
- SATURATE, 0, 0 = wrap at limits, 1 = hold at limits.

Ports:
- clk  input  1  counter clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- clr  input  1  synchronous clear to 0 (not RESET_VAL).
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value to load.
- en  input  1  count enable.
- up_dn  input  1  1 = count up, 0 = count down.
- q  output  WIDTH  current count (registered).
- tc_o  output  1  terminal count (combinational).
- wrap_o  output  1  registered one-cycle pulse on a wrap event.
- ovf_o  output  1  registered sticky limit-hit flag.

Behaviour:
- Reset: one clock; reset is synchronous and active-high (clk, rst). On a rising clk with rst=1:
  - q=RESET_VAL
  - wrap_o=0
  - ovf_o=0
- Priority per rising edge: rst > clr > load > en. Lower-priority inputs are ignored when a higher one is active.
- clr=1: q=0, wrap_o=0, ovf_o=0.
- load=1:
  - q = min(load_val, MAX_VAL); out-of-range values clamp to MAX_VAL.
  - wrap_o=0; ovf_o unchanged.
- en=1, up_dn=1:
  - q<MAX_VAL: q=q+1.
  - q==MAX_VAL, SATURATE=0: q=0, wrap_o=1 next cycle, ovf_o=1.
  - q==MAX_VAL, SATURATE=1: q holds, wrap_o=0, ovf_o=1.
- en=1, up_dn=0:
  - q>0: q=q-1.
  - q==0, SATURATE=0: q=MAX_VAL, wrap_o=1, ovf_o=1.
  - q==0, SATURATE=1: q holds at 0, wrap_o=0, ovf_o=1.
- en=0 (no rst/clr/load): q holds, wrap_o=0, ovf_o holds.
- wrap_o: high for exactly the one cycle following the wrapping edge. Back-to-back wraps (e.g. MAX_VAL=0) keep it high continuously.
- tc_o = en & ((up_dn & q==MAX_VAL) | (~up_dn & q==0)).
  - Independent of load/clr.
  - Cascade rule: the next stage's en = tc_o of the previous stage.
- Direction change mid-count takes effect on the next edge; there is no pipeline delay.
- MAX_VAL=0 edge case: q is always 0. While en=1, tc_o=1; each enabled edge is a wrap (SATURATE=0) or a hold (SATURATE=1).
- Arithmetic: compare against MAX_VAL using the full WIDTH. There are no intermediate values wider than WIDTH+1; no arithmetic overflow beyond MAX_VAL is possible.
- Reset mid-count overrides any pending load/en/clr on the same edge.
- All outputs are X-free after the first reset edge. Before reset, outputs are don't-care.

Test Plan:
1. WIDTH=4, default MAX_VAL, SATURATE=0: rst, then en=1, up_dn=1 for 17 edges.
   - q steps 0..15 then 0.
   - tc_o=1 while q=15.
   - wrap_o=1 for one cycle after the 15→0 edge.
   - ovf_o=1 and sticky thereafter.
2. MAX_VAL=9, up_dn=0 from q=0, en=1.
   - Next q=9, wrap_o pulse, then q=8,7,….
   - Loading load_val=12 gives q=9 (clamp).
3. SATURATE=1, MAX_VAL=9.
   - Count up from 7: q=8,9,9,9; wrap_o stays 0; ovf_o=1 from the edge at q=9.
   - Switch up_dn=0: q=8 next edge.
4. Priority: q=5, assert rst, clr, load(load_val=3) and en together.
   - q=RESET_VAL; ovf_o=0.
   - Then clr+load(3)+en: q=0.
   - Then load(3)+en: q=3.
5. Cascade: two instances (WIDTH=4) with the second en = first tc_o, both up.
   - After 256 enabled edges from 0, both q=0.
   - Second stage's wrap_o pulses exactly once.
   - Combined value tracks 0..255.
6. Mid-operation: q=12, ovf_o=1, en=0 for 5 cycles → q=12, wrap_o=0.
   - Then clr: q=0, ovf_o=0.
